// File: rtl/rightshift_seq_if.sv
// Bus bundle between the ALU control and the sequential right shifter.
// Latency: none, wires only.
// Backpressure: none; the requester watches busy / data_resultRDY.
interface rightshift_seq_if;
  logic        ctrl_start;
  logic        ctrl_arith;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  // Requester side (ALU control / testbench)
  modport master (
    output ctrl_start, ctrl_arith, operand, shamt,
    input  data_result, data_resultRDY, busy
  );

  // Shifter side
  modport slave (
    input  ctrl_start, ctrl_arith, operand, shamt,
    output data_result, data_resultRDY, busy
  );
endinterface

// File: rtl/rightshift_seq.sv
// Sequential 32-bit logical/arithmetic right shifter, one barrel stage per clock (16,8,4,2,1).
// Latency: fixed 5 cycles from start acceptance to a one-cycle data_resultRDY pulse.
// Backpressure: start is only accepted in IDLE or DONE; starts during SHIFT are dropped.
module rightshift_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  rightshift_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  // Stage select: shift distance 16>>k, controlled by amount bit 4-k.
  logic [WIDTH-1:0]   stage_shifted;
  logic               stage_en;
  logic [WIDTH-1:0]   stage_out;

  // Current barrel stage: one 2:1 mux between acc and acc shifted by the stage distance
  always_comb begin
    stage_shifted = acc_q;
    stage_en      = 1'b0;
    case (k_q)
      3'd0: begin
        stage_shifted = {{16{fill_q}}, acc_q[31:16]};
        stage_en      = amt_q[4];
      end
      3'd1: begin
        stage_shifted = {{8{fill_q}}, acc_q[31:8]};
        stage_en      = amt_q[3];
      end
      3'd2: begin
        stage_shifted = {{4{fill_q}}, acc_q[31:4]};
        stage_en      = amt_q[2];
      end
      3'd3: begin
        stage_shifted = {{2{fill_q}}, acc_q[31:2]};
        stage_en      = amt_q[1];
      end
      3'd4: begin
        stage_shifted = {fill_q, acc_q[31:1]};
        stage_en      = amt_q[0];
      end
      default: begin
        stage_shifted = acc_q;
        stage_en      = 1'b0;
      end
    endcase
    stage_out = stage_en ? stage_shifted : acc_q;
  end

  // Next-state logic: acceptance, stage stepping, and the one-cycle DONE pulse
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    amt_d    = amt_q;
    fill_d   = fill_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.ctrl_start) begin
          acc_d   = bus.operand;
          amt_d   = bus.shamt;
          fill_d  = bus.ctrl_arith & bus.operand[31];
          k_d     = 3'd0;
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        acc_d = stage_out;
        if (k_q == 3'd4) begin
          // Last stage: publish the result directly from the mux output
          state_d  = ST_DONE;
          result_d = stage_out;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          k_d      = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, even mid-shift
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      k_q      <= 3'd0;
      acc_q    <= '0;
      amt_q    <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      amt_q    <= amt_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
